// File: rtl/hist_ram_updater.sv
// hist_ram_updater
//   Histogram engine that sits in front of a simple dual-port RAM (one read
//   port, one write port) and acts as its only initiator. It does three jobs:
//     - ACCUM  : pipelined read-modify-write increments, one bin per clock,
//                with forwarding so that repeated bins count exactly
//     - CLEAR  : sweeps every address and writes zero
//     - READOUT: streams every bin count out over a valid/ready interface
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   in_valid_i/in_ready_o/in_bin_i    sample stream (bin to increment)
//   clear_start_i, readout_start_i    single-cycle command pulses (ACCUM only)
//   busy_o                      drain / clear / readout in progress
//   out_valid_o/out_ready_i/out_bin_o/out_count_o/out_last_o  readout stream
//   ram_rdaddress_o, ram_q_i    RAM read port (RD_LAT clocks address-to-data)
//   ram_wraddress_o, ram_data_o, ram_wren_o   RAM write port
module hist_ram_updater #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_bin_i,
  input  logic              clear_start_i,
  input  logic              readout_start_i,
  output logic              busy_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_bin_o,
  output logic [DATA_W-1:0] out_count_o,
  output logic              out_last_o,
  output logic [ADDR_W-1:0] ram_rdaddress_o,
  output logic [ADDR_W-1:0] ram_wraddress_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_wren_o,
  input  logic [DATA_W-1:0] ram_q_i
);

  localparam int WAIT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ACCUM   = 3'd1,
    S_DRAIN_C = 3'd2,
    S_CLEAR   = 3'd3,
    S_DRAIN_R = 3'd4,
    S_READOUT = 3'd5
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [WAIT_W-1:0]   wait_q;
  logic                out_valid_q;
  logic [ADDR_W-1:0]   out_bin_q;
  logic [DATA_W-1:0]   out_count_q;
  logic                out_last_q;

  // Update pipeline: index i holds the sample accepted i+1 cycles ago.
  logic [RD_LAT-1:0]   stg_vld_q;
  logic [ADDR_W-1:0]   stg_bin_q  [RD_LAT];
  // Write history: index 0 is the write committed in the previous cycle.
  logic [RD_LAT-1:0]   hist_vld_q;
  logic [ADDR_W-1:0]   hist_bin_q [RD_LAT];
  logic [DATA_W-1:0]   hist_cnt_q [RD_LAT];

  logic                accept_s;
  logic                wr_acc_s;
  logic [ADDR_W-1:0]   wr_bin_s;
  logic [DATA_W-1:0]   base_s;
  logic [DATA_W-1:0]   new_cnt_s;
  logic                pipe_idle_s;

  assign accept_s    = in_valid_i & (state_q == S_ACCUM);
  assign wr_acc_s    = stg_vld_q[RD_LAT-1];
  assign wr_bin_s    = stg_bin_q[RD_LAT-1];
  assign pipe_idle_s = ~(|stg_vld_q);

  assign in_ready_o  = (state_q == S_ACCUM);
  assign busy_o      = (state_q == S_DRAIN_C) | (state_q == S_CLEAR) |
                       (state_q == S_DRAIN_R) | (state_q == S_READOUT);
  assign out_valid_o = out_valid_q;
  assign out_bin_o   = out_bin_q;
  assign out_count_o = out_count_q;
  assign out_last_o  = out_last_q;

  // Base count selection: the RAM returns stale data for any write made during
  // the last RD_LAT cycles, so the newest matching history entry wins.
  always_comb begin
    base_s = ram_q_i;
    for (int i = RD_LAT - 1; i >= 0; i--) begin
      base_s = (hist_vld_q[i] && (hist_bin_q[i] == wr_bin_s)) ? hist_cnt_q[i] : base_s;
    end
    new_cnt_s = (&base_s) ? base_s : (base_s + DATA_W'(1));
  end

  // RAM port steering: stage 0 reads straight from the input in ACCUM.
  always_comb begin
    if (state_q == S_ACCUM) begin
      ram_rdaddress_o = in_bin_i;
    end else begin
      ram_rdaddress_o = rd_addr_q;
    end
    if (state_q == S_CLEAR) begin
      ram_wren_o      = 1'b1;
      ram_wraddress_o = clr_addr_q;
      ram_data_o      = '0;
    end else if (wr_acc_s) begin
      ram_wren_o      = 1'b1;
      ram_wraddress_o = wr_bin_s;
      ram_data_o      = new_cnt_s;
    end else begin
      ram_wren_o      = 1'b0;
      ram_wraddress_o = '0;
      ram_data_o      = '0;
    end
  end

  // Update pipeline and write history shift registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stg_vld_q  <= '0;
      hist_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        stg_bin_q[i]  <= '0;
        hist_bin_q[i] <= '0;
        hist_cnt_q[i] <= '0;
      end
    end else begin
      stg_vld_q[0] <= accept_s;
      stg_bin_q[0] <= in_bin_i;
      for (int i = 1; i < RD_LAT; i++) begin
        stg_vld_q[i] <= stg_vld_q[i-1];
        stg_bin_q[i] <= stg_bin_q[i-1];
      end
      if (state_q == S_CLEAR) begin
        // RAM is being zeroed; any remembered value is now wrong.
        hist_vld_q <= '0;
      end else begin
        hist_vld_q[0] <= wr_acc_s;
        hist_bin_q[0] <= wr_bin_s;
        hist_cnt_q[0] <= new_cnt_s;
        for (int i = 1; i < RD_LAT; i++) begin
          hist_vld_q[i] <= hist_vld_q[i-1];
          hist_bin_q[i] <= hist_bin_q[i-1];
          hist_cnt_q[i] <= hist_cnt_q[i-1];
        end
      end
    end
  end

  // Control FSM with clear sweep and readout sequencing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      clr_addr_q  <= '0;
      rd_addr_q   <= '0;
      wait_q      <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_ACCUM;
        S_ACCUM: begin
          if (clear_start_i) begin
            state_q <= S_DRAIN_C;
          end else if (readout_start_i) begin
            state_q <= S_DRAIN_R;
          end else begin
            state_q <= S_ACCUM;
          end
        end
        S_DRAIN_C: begin
          if (pipe_idle_s) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
          end
        end
        S_CLEAR: begin
          if (clr_addr_q == '1) begin
            state_q <= S_ACCUM;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN_R: begin
          if (pipe_idle_s) begin
            state_q     <= S_READOUT;
            rd_addr_q   <= '0;
            wait_q      <= '0;
            out_valid_q <= 1'b0;
          end
        end
        S_READOUT: begin
          // rd_addr_q is held per word, so ram_q_i stays valid once RD_LAT has elapsed.
          if (!out_valid_q) begin
            if (wait_q == WAIT_W'(RD_LAT)) begin
              out_valid_q <= 1'b1;
              out_bin_q   <= rd_addr_q;
              out_count_q <= ram_q_i;
              out_last_q  <= (rd_addr_q == '1);
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
            end
          end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            wait_q      <= '0;
            if (out_last_q) begin
              state_q <= S_ACCUM;
            end else begin
              rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
